// File: rtl/motion_update_bcast_ctrl.sv
// motion_update_bcast_ctrl
// Round-robin sequencer that moves particle results from NUM_REQ motion-update
// units onto the single broadcast bus. It keeps out_motion_update_enable high
// while the run is in progress. It then waits out the caches' buffer swap
// before pulsing out_done.
//
// Handshake: a requester transfers one particle in a cycle where its
// in_req_valid and out_req_ready are both high. A requester holds valid, data
// and last stable until that cycle. Ready is combinational and is given to at
// most one requester per cycle.
//
// Optional feature: define MU_BCAST_TIMEOUT_EN to build the idle-handshake
// watchdog. Without it, out_timeout is tied low.
module motion_update_bcast_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int CELL_ID_WIDTH  = 4,
    parameter int NUM_REQ        = 4,
    parameter int SWAP_WAIT      = 3,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [NUM_REQ-1:0]                 in_req_active,
    input  logic [NUM_REQ-1:0]                 in_req_valid,
    input  logic [NUM_REQ-1:0]                 in_req_last,
    input  logic [NUM_REQ*3*DATA_WIDTH-1:0]    in_req_data,
    input  logic [NUM_REQ*3*CELL_ID_WIDTH-1:0] in_req_dst_cell,
    output logic [NUM_REQ-1:0]                 out_req_ready,
    output logic                               out_motion_update_enable,
    output logic [3*DATA_WIDTH-1:0]            out_data,
    output logic [3*CELL_ID_WIDTH-1:0]         out_data_dst_cell,
    output logic                               out_data_valid,
    output logic                               out_busy,
    output logic                               out_done,
    output logic [CNT_WIDTH-1:0]               out_particle_count,
    output logic                               out_timeout,
    output logic [1:0]                         fsm_state
);

    localparam int VW     = 3 * DATA_WIDTH;
    localparam int DW     = 3 * CELL_ID_WIDTH;
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WAIT_W = (SWAP_WAIT > 1) ? $clog2(SWAP_WAIT + 1) : 1;
    localparam logic [PTR_W:0]   NUM_REQ_W  = (PTR_W + 1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NUM_REQ - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SWAP_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_BROADCAST = 2'd1,
        S_DRAIN     = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [NUM_REQ-1:0]  done_mask;
    logic [PTR_W-1:0]    ptr;
    logic [WAIT_W-1:0]   wait_cnt;

    logic [NUM_REQ-1:0]  eligible;
    logic                grant_found;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W:0]      rr_idx;
    logic                handshake;
    logic                start_accept;
    logic                all_done;
    logic                drain_end;
    logic                watchdog_fire;
    logic [VW-1:0]       sel_data;
    logic [DW-1:0]       sel_dst;
    logic                sel_last;
    logic [PTR_W-1:0]    ptr_next;

    assign all_done     = &done_mask;
    assign drain_end    = (wait_cnt == WAIT_LAST);
    assign start_accept = (state == S_IDLE) && start;
    assign handshake    = (state == S_BROADCAST) && grant_found;
    assign ptr_next     = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    assign fsm_state    = state;

    // Round-robin search from the pointer over requesters still owing particles
    always_comb begin
        eligible      = in_req_valid & ~done_mask;
        grant_found   = 1'b0;
        grant_idx     = '0;
        rr_idx        = '0;
        out_req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_idx = {1'b0, ptr} + (PTR_W + 1)'(k);
            if (rr_idx >= NUM_REQ_W) begin
                rr_idx = rr_idx - NUM_REQ_W;
            end
            if (!grant_found && eligible[rr_idx[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = rr_idx[PTR_W-1:0];
            end
        end
        if (state == S_BROADCAST && grant_found) begin
            out_req_ready[grant_idx] = 1'b1;
        end
    end

    // Select the granted requester's payload
    always_comb begin
        sel_data = in_req_data[grant_idx*VW +: VW];
        sel_dst  = in_req_dst_cell[grant_idx*DW +: DW];
        sel_last = in_req_last[grant_idx];
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and state-decoded outputs
    always_comb begin
        state_next               = state;
        out_motion_update_enable = 1'b0;
        out_busy                 = 1'b1;
        out_done                 = 1'b0;
        case (state)
            S_IDLE: begin
                out_busy = 1'b0;
                if (start) begin
                    state_next = S_BROADCAST;
                end
            end
            S_BROADCAST: begin
                out_motion_update_enable = 1'b1;
                if (all_done) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_end) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_done   = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Per-requester completion mask: inactive requesters start out finished
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_mask <= '0;
        end else if (start_accept) begin
            done_mask <= ~in_req_active;
        end else if (state == S_BROADCAST) begin
            if (watchdog_fire) begin
                done_mask <= '1;
            end else if (handshake && sel_last) begin
                done_mask[grant_idx] <= 1'b1;
            end
        end
    end

    // Round-robin pointer moves past each granted requester
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (handshake) begin
            ptr <= ptr_next;
        end
    end

    // Registered broadcast bus; data holds its last value between particles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data          <= '0;
            out_data_dst_cell <= '0;
            out_data_valid    <= 1'b0;
        end else begin
            out_data_valid <= handshake;
            if (handshake) begin
                out_data          <= sel_data;
                out_data_dst_cell <= sel_dst;
            end
        end
    end

    // Saturating broadcast counter, cleared on each accepted start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_particle_count <= '0;
        end else if (start_accept) begin
            out_particle_count <= '0;
        end else if (handshake && (out_particle_count != {CNT_WIDTH{1'b1}})) begin
            out_particle_count <= out_particle_count + 1'b1;
        end
    end

    // Swap-wait counter runs only while draining
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state == S_DRAIN) begin
            wait_cnt <= drain_end ? '0 : wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

`ifdef MU_BCAST_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] idle_cnt;

    // Fires on the last of TIMEOUT_CYCLES consecutive handshake-free cycles
    assign watchdog_fire = (state == S_BROADCAST) && !handshake && !all_done &&
                           (idle_cnt == TO_LAST);

    // Idle-cycle counter and sticky timeout flag, both cleared by a new run
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt    <= '0;
            out_timeout <= 1'b0;
        end else if (start_accept) begin
            idle_cnt    <= '0;
            out_timeout <= 1'b0;
        end else if (state == S_BROADCAST) begin
            if (handshake || watchdog_fire) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
            if (watchdog_fire) begin
                out_timeout <= 1'b1;
            end
        end
    end
`else
    assign watchdog_fire = 1'b0;
    assign out_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_motion_update_bcast_ctrl.sv
// Bench for motion_update_bcast_ctrl. Requesters are driven from per-requester
// particle budgets. A cycle model predicts every output on each cycle, and
// literal expectations pin broadcast order, latencies and counts.
module tb_motion_update_bcast_ctrl;

    localparam int DW   = 8;
    localparam int CW   = 4;
    localparam int NR   = 4;
    localparam int SW   = 3;
    localparam int CNTW = 16;
    localparam int TO   = 16;
    localparam int VW   = 3 * DW;
    localparam int DSTW = 3 * CW;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic [NR-1:0]        act = '0;
    logic [NR-1:0]        valid = '0;
    logic [NR-1:0]        last = '0;
    logic [NR*VW-1:0]     data = '0;
    logic [NR*DSTW-1:0]   dst = '0;
    logic [NR-1:0]        ready;
    logic                 enable;
    logic [VW-1:0]        out_data;
    logic [DSTW-1:0]      out_dst;
    logic                 out_valid;
    logic                 busy;
    logic                 done;
    logic [CNTW-1:0]      count;
    logic                 timeout;
    logic [1:0]           fsm_state;

    motion_update_bcast_ctrl #(
        .DATA_WIDTH(DW), .CELL_ID_WIDTH(CW), .NUM_REQ(NR), .SWAP_WAIT(SW),
        .CNT_WIDTH(CNTW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_req_active(act), .in_req_valid(valid), .in_req_last(last),
        .in_req_data(data), .in_req_dst_cell(dst),
        .out_req_ready(ready), .out_motion_update_enable(enable),
        .out_data(out_data), .out_data_dst_cell(out_dst),
        .out_data_valid(out_valid), .out_busy(busy), .out_done(done),
        .out_particle_count(count), .out_timeout(timeout), .fsm_state(fsm_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, actual, expected, cyc);
        end
    endtask

    // Requester stimulus state
    int rem[NR];
    int gap[NR];
    int gap_cnt[NR];
    bit no_last[NR];
    bit hs_seen[NR];

    // Driver: each requester offers its remaining particles, with gaps after handshakes
    initial begin
        for (int i = 0; i < NR; i++) begin
            rem[i] = 0; gap[i] = 0; gap_cnt[i] = 0; no_last[i] = 0; hs_seen[i] = 0;
        end
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NR; i++) begin
                if (hs_seen[i]) begin
                    rem[i]--;
                    gap_cnt[i] = gap[i];
                    hs_seen[i] = 0;
                end
                valid[i] = (rem[i] > 0) && (gap_cnt[i] == 0);
                if (!valid[i] && gap_cnt[i] > 0) gap_cnt[i]--;
                last[i] = (rem[i] == 1) && !no_last[i];
                data[i*VW +: VW] = {8'(i * 16 + rem[i]), 8'(8'h5A ^ rem[i]), 8'(8'hA0 + i)};
                dst[i*DSTW +: DSTW] = {4'(i), 4'(rem[i]), 4'(i + rem[i] * 3)};
            end
        end
    end

    // Behavioural model of the expected outputs
    bit              m_en;
    int              m_wait;
    bit              m_done;
    bit [NR-1:0]     m_fin;
    int              m_ptr;
    int              m_count;
    bit              m_vld;
    logic [VW-1:0]   m_data;
    logic [DSTW-1:0] m_dst;
    bit              m_to;
    int              m_idle;

    // Observation logs for literal checks
    int hs_log[$];
    int last_hs_cyc, en_cycles, en_first_cyc, done_cyc, done_count;
    int valid_pulses, ready_other, to_cyc;
    bit to_prev;

    task automatic model_reset();
        m_en = 0; m_wait = 0; m_done = 0; m_fin = '0; m_ptr = 0; m_count = 0;
        m_vld = 0; m_data = '0; m_dst = '0; m_to = 0; m_idle = 0;
    endtask

    task automatic model_step(input bit found, input int g);
        bit all_fin;
        all_fin = &m_fin;
        if (m_en) begin
            if (found) begin
                m_vld  = 1;
                m_data = data[g*VW +: VW];
                m_dst  = dst[g*DSTW +: DSTW];
                if (m_count < 65535) m_count++;
                m_ptr  = (g + 1) % NR;
                if (last[g]) m_fin[g] = 1'b1;
                m_idle = 0;
            end else begin
                m_vld = 0;
`ifdef MU_BCAST_TIMEOUT_EN
                if (!all_fin) begin
                    m_idle++;
                    if (m_idle == TO) begin
                        m_fin  = '1;
                        m_to   = 1;
                        m_idle = 0;
                    end
                end
`endif
            end
            if (all_fin) begin
                m_en   = 0;
                m_wait = SW;
            end
        end else begin
            m_vld = 0;
            if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) m_done = 1;
            end else if (m_done) begin
                m_done = 0;
            end else if (start) begin
                m_fin   = ~act;
                m_count = 0;
                m_en    = 1;
                m_to    = 0;
                m_idle  = 0;
            end
        end
    endtask

    // Compare process: outputs vs model every cycle, then advance the model
    always @(negedge clk) begin
        int g;
        bit found;
        logic [NR-1:0] exp_ready;
        if (!rst) begin
            model_reset();
        end else begin
            found = 0;
            g = 0;
            if (m_en) begin
                for (int k = 0; k < NR; k++) begin
                    int i;
                    i = (m_ptr + k) % NR;
                    if (!found && valid[i] && !m_fin[i]) begin
                        found = 1;
                        g = i;
                    end
                end
            end
            exp_ready = found ? (NR'(1) << g) : '0;
            chk("enable", enable, m_en);
            chk("busy", busy, m_en || (m_wait > 0) || m_done);
            chk("done", done, m_done);
            chk("data_valid", out_valid, m_vld);
            chk("ready", ready, exp_ready);
            chk("count", count, m_count);
            chk("timeout", timeout, m_to);
            if (m_vld) begin
                chk("data", out_data, m_data);
                chk("dst_cell", out_dst, m_dst);
            end
            for (int i = 0; i < NR; i++) begin
                if (ready[i] && valid[i]) begin
                    hs_seen[i] = 1;
                    hs_log.push_back(i);
                    last_hs_cyc = cyc;
                end
            end
            if ((ready & ~(NR'(1) << 2)) != '0) ready_other++;
            if (enable) begin
                if (en_cycles == 0) en_first_cyc = cyc;
                en_cycles++;
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
            if (out_valid) valid_pulses++;
            if (timeout && !to_prev) to_cyc = cyc;
            to_prev = timeout;
            model_step(found, g);
        end
    end

    task automatic clear_logs();
        hs_log.delete();
        last_hs_cyc = 0; en_cycles = 0; en_first_cyc = 0; done_cyc = 0;
        valid_pulses = 0; ready_other = 0; to_cyc = 0;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NR; i++) begin
            rem[i] = 0; gap[i] = 0; gap_cnt[i] = 0; no_last[i] = 0; hs_seen[i] = 0;
        end
    endtask

    task automatic pulse_start(input logic [NR-1:0] a);
        @(posedge clk);
        #1;
        act   = a;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int c0;
        int n;
        c0 = done_count;
        n = 0;
        while (done_count == c0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(nm, done_count != c0, 1'b1);
        #1;
    endtask

    // Hard stop in case a stimulus step never returns
    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    // Directed test sequence
    initial begin
        int c_before;
        int n;
        clear_logs();
        done_count = 0;
        to_prev = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_enable", enable, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", ready, 0);
        chk("rst_count", count, 0);
        chk("rst_data", out_data, 0);
        chk("rst_dst", out_dst, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_state", fsm_state, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single run: four requesters, three particles each
        for (int i = 0; i < NR; i++) rem[i] = 3;
        clear_logs();
        pulse_start(4'hF);
        wait_done(200, "t1_done_seen");
        chk("t1_count", count, 12);
        chk("t1_bcasts", hs_log.size(), 12);
        for (int k = 0; k < hs_log.size() && k < 12; k++) chk("t1_order", hs_log[k], k % 4);
        chk("t1_done_latency", done_cyc - last_hs_cyc, 5);

        // All requesters inactive
        clear_reqs();
        clear_logs();
        pulse_start(4'h0);
        wait_done(50, "t2_done_seen");
        chk("t2_enable_cycles", en_cycles, 1);
        chk("t2_valid_pulses", valid_pulses, 0);
        chk("t2_done_latency", done_cyc - en_first_cyc, 4);
        chk("t2_count", count, 0);

        // Only req2 active, gaps in valid; inactive requesters also assert valid
        clear_reqs();
        rem[0] = 4; rem[1] = 4; rem[3] = 4;
        rem[2] = 5; gap[2] = 2;
        clear_logs();
        pulse_start(4'b0100);
        wait_done(200, "t3_done_seen");
        chk("t3_valid_pulses", valid_pulses, 5);
        chk("t3_ready_other", ready_other, 0);
        chk("t3_bcasts", hs_log.size(), 5);
        chk("t3_count", count, 5);

        // Stray start during DRAIN is ignored
        clear_reqs();
        rem[0] = 1; rem[1] = 1;
        clear_logs();
        c_before = done_count;
        pulse_start(4'b0011);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (enable && n < 50);
        chk("t4_enable_fell", enable, 0);
        pulse_start(4'hF);
        wait_done(50, "t4_done_seen");
        repeat (10) @(posedge clk);
        #1;
        chk("t4_done_pulses", done_count - c_before, 1);
        chk("t4_count", count, 2);
        clear_reqs();
        rem[3] = 2;
        pulse_start(4'b1000);
        wait_done(50, "t4_fresh_done_seen");
        chk("t4_fresh_count", count, 2);

        // Reset asserted mid-BROADCAST
        clear_reqs();
        for (int i = 0; i < NR; i++) rem[i] = 10;
        pulse_start(4'hF);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("t5_rst_enable", enable, 0);
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        clear_reqs();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_state_idle", fsm_state, 0);
        chk("t5_busy_after", busy, 0);
        rem[1] = 1;
        pulse_start(4'b0010);
        wait_done(50, "t5_recover_done_seen");
        chk("t5_recover_count", count, 1);

`ifdef MU_BCAST_TIMEOUT_EN
        // Watchdog: req1 never raises last
        clear_reqs();
        rem[1] = 2;
        no_last[1] = 1;
        clear_logs();
        pulse_start(4'b0010);
        wait_done(200, "t6_done_seen");
        chk("t6_timeout_latency", to_cyc - last_hs_cyc, 17);
        chk("t6_timeout_sticky", timeout, 1);
        chk("t6_count", count, 2);
        clear_reqs();
        pulse_start(4'h0);
        chk("t6_timeout_cleared", timeout, 0);
        wait_done(50, "t6_second_done_seen");
`else
        chk("timeout_tied_low", timeout, 0);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/motion_update_bcast_ctrl.md
# motion_update_bcast_ctrl

Sequencer and arbiter for the motion-update broadcast bus feeding every per-cell velocity/position double-buffered cache. It takes particle results from NUM_REQ motion-update units and round-robins them onto the single broadcast bus. It holds `out_motion_update_enable` high for the whole process, then drops it and waits out the caches' buffer-swap sequence before reporting done.

## Interface
Parameters:
- DATA_WIDTH, 32, width of one velocity component; the bus carries 3*DATA_WIDTH as {vz, vy, vx}
- CELL_ID_WIDTH, 4, width of one cell coordinate; the destination is 3*CELL_ID_WIDTH as {x, y, z}
- NUM_REQ, 4, number of motion-update requesters (2..8)
- SWAP_WAIT, 3, cycles after the enable falls before caches are back in their idle state
- CNT_WIDTH, 16, width of the broadcast particle counter
- TIMEOUT_CYCLES, 1024, idle-handshake limit (only used with the macro)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a motion update
- in_req_active  in  NUM_REQ  participating requesters, sampled on an accepted start
- in_req_valid  in  NUM_REQ  per-requester particle valid
- in_req_last  in  NUM_REQ  marks the requester's final particle
- in_req_data  in  NUM_REQ*3*DATA_WIDTH  requester i occupies slice i
- in_req_dst_cell  in  NUM_REQ*3*CELL_ID_WIDTH  destination cell per requester
- out_req_ready  out  NUM_REQ  one-hot grant, combinational
- out_motion_update_enable  out  1  to all caches
- out_data  out  3*DATA_WIDTH  broadcast data, registered
- out_data_dst_cell  out  3*CELL_ID_WIDTH  broadcast destination, registered
- out_data_valid  out  1  broadcast valid, registered
- out_busy  out  1  high in any state other than IDLE
- out_done  out  1  one-cycle pulse when the swap is complete
- out_particle_count  out  CNT_WIDTH  particles broadcast in this run; holds its value after done
- out_timeout  out  1  sticky watchdog flag

## Operation
- FSM states: IDLE, BROADCAST, DRAIN, DONE.
- IDLE:
  - On start, latch done_mask = ~in_req_active, clear the counter and out_timeout, and go to BROADCAST.
  - In IDLE, start is the only input that has an effect.
- BROADCAST:
  - Enable is high.
  - The round-robin pointer grants the first requester with valid set and its done_mask bit clear, searching from the pointer.
  - out_req_ready is set only for that requester.
  - A handshake occurs when valid & ready. On a handshake:
    - Register data, destination and valid=1.
    - Increment the counter, saturating at all-ones.
    - Move the pointer to grant+1 (mod NUM_REQ).
    - If last is set, set that requester's done_mask bit.
  - When done_mask is all-ones, go to DRAIN.
- DRAIN:
  - Enable and valid are low.
  - Count SWAP_WAIT cycles, then go to DONE.
- DONE: pulse out_done and return to IDLE.
- A start outside IDLE is ignored (no queuing).
- If in_req_active is all-zero, enable is high for exactly 1 cycle, followed by DRAIN.
- out_data_valid never coincides with enable low.
- At most one grant per cycle; ready is never given to a requester that is done or inactive.

## Timing
- Reset values:
  - state IDLE, all outputs 0, pointer 0, done_mask 0.
  - out_data and out_data_dst_cell are 0.
- Start accepted at cycle t: enable is high from t+1.
- Handshake at cycle t: out_data_valid is high at t+1 only, while enable is still high.
- Final last handshake at cycle t:
  - Broadcast at t+1.
  - Enable falls at t+2.
  - out_done pulses at t+2+SWAP_WAIT.
  - Start is accepted again from t+3+SWAP_WAIT.
- Reset mid-run:
  - Immediate return to IDLE with enable low.
  - Caches are reset in the same domain.

## Configuration
- MU_BCAST_TIMEOUT_EN defined:
  - In BROADCAST, if TIMEOUT_CYCLES consecutive cycles pass with no handshake, force done_mask to all-ones and set out_timeout.
  - The FSM proceeds to DRAIN normally.
  - out_timeout stays high until the next accepted start.
- MU_BCAST_TIMEOUT_EN undefined: no watchdog logic; out_timeout is tied to 0.

## Test plan
- Single run: NUM_REQ=4, all active, each sends 3 particles with last on the third, valid held high. Required: 12 broadcasts in order req0,1,2,3,0,1,…; count=12; done pulses 2+3 cycles after the last handshake.
- All requesters inactive on start. Required: enable high 1 cycle, no valid, done 4 cycles later, count=0.
- Only req2 active with 5 particles and gaps in valid. Required: ready only on bit 2; 5 broadcasts, each 1 cycle after its handshake.
- Second start pulsed during DRAIN. Required: ignored; exactly one done pulse; a fresh start afterward runs normally.
- Reset asserted mid-BROADCAST. Required: enable, valid and busy go to 0 asynchronously; FSM is in IDLE after release.
- With MU_BCAST_TIMEOUT_EN, TIMEOUT_CYCLES=16, req1 never raises last. Required: out_timeout set after 16 idle cycles, then DRAIN and done; the flag clears on the next start.
